// File: rtl/conv_window_ctrl.sv
// rtl/conv_window_ctrl.sv - column-read / window-shift sequencer feeding a conv MAC array
// Optional stride-2 support is compiled in when CONV_STRIDE2_EN is defined.
module conv_window_ctrl #(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_img_w,
  input  logic [DIM_W-1:0]  cfg_img_h,
  input  logic [ADDR_W-1:0] cfg_base,
`ifdef CONV_STRIDE2_EN
  input  logic              cfg_stride2,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              load_en,
  output logic              win_valid,
  input  logic              mac_ready,
  output logic [DIM_W-1:0]  out_row,
  output logic [DIM_W-1:0]  out_col,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(K_W + 2);

  localparam logic [DIM_W-1:0]  KW_D  = DIM_W'(K_W);
  localparam logic [DIM_W-1:0]  KH_D  = DIM_W'(K_H);
  localparam logic [DIM_W-1:0]  ONE_D = DIM_W'(1);
  localparam logic [CNT_W-1:0]  KW_C  = CNT_W'(K_W);
  localparam logic [CNT_W-1:0]  ONE_C = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TWO_C = CNT_W'(2);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_STEP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              load_en_q, load_en_d;
  logic              win_valid_q, win_valid_d;
  logic [DIM_W-1:0]  out_row_q, out_row_d;
  logic [DIM_W-1:0]  out_col_q, out_col_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DIM_W-1:0]  img_w_q, img_w_d;
  logic [DIM_W-1:0]  ow_q, ow_d;
  logic [DIM_W-1:0]  oh_q, oh_d;
  logic [ADDR_W-1:0] row_addr_q, row_addr_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic              stride2_q, stride2_d;

  logic              start_s2;
  logic              cfg_bad;
  logic [DIM_W-1:0]  w_span;
  logic [DIM_W-1:0]  h_span;
  logic [CNT_W-1:0]  need;
  logic [CNT_W-1:0]  rd_cnt_inc;
  logic [ADDR_W-1:0] row_step;

`ifdef CONV_STRIDE2_EN
  assign start_s2 = cfg_stride2;
`else
  assign start_s2 = 1'b0;
`endif

  assign cfg_bad  = (cfg_img_w < KW_D) || (cfg_img_h < KH_D);
  assign w_span   = cfg_img_w - KW_D;
  assign h_span   = cfg_img_h - KH_D;
  // Address distance between the top rows of vertically adjacent windows.
  assign row_step = stride2_q ? (ADDR_W'(img_w_q) << 1) : ADDR_W'(img_w_q);

  // Next-state logic: reads run back-to-back, each load trails its read by one cycle,
  // and the window is only presented once every load for the phase has landed.
  always_comb begin
    state_d     = state_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    load_en_d   = rd_en_q;
    win_valid_d = win_valid_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    err_d       = err_q;
    img_w_d     = img_w_q;
    ow_d        = ow_q;
    oh_d        = oh_q;
    row_addr_d  = row_addr_q;
    rd_cnt_d    = rd_cnt_q;
    ld_cnt_d    = ld_cnt_q;
    stride2_d   = stride2_q;
    need        = (state_q == S_FILL) ? KW_C : (stride2_q ? TWO_C : ONE_C);
    rd_cnt_inc  = rd_cnt_q + ONE_C;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          img_w_d   = cfg_img_w;
          stride2_d = start_s2;
          ow_d      = (start_s2 ? (w_span >> 1) : w_span) + ONE_D;
          oh_d      = (start_s2 ? (h_span >> 1) : h_span) + ONE_D;
          out_row_d = '0;
          out_col_d = '0;
          rd_cnt_d  = '0;
          ld_cnt_d  = '0;
          if (cfg_bad) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d      = 1'b0;
            state_d    = S_FILL;
            rd_en_d    = 1'b1;
            rd_addr_d  = cfg_base;
            row_addr_d = cfg_base;
          end
        end
      end

      S_FILL, S_STEP: begin
        if (rd_en_q) begin
          rd_cnt_d = rd_cnt_inc;
          if (rd_cnt_inc < need) begin
            rd_en_d   = 1'b1;
            rd_addr_d = rd_addr_q + ONE_A;
          end
        end
        if (load_en_q) begin
          if (ld_cnt_q == need - ONE_C) begin
            ld_cnt_d    = '0;
            state_d     = S_WAIT;
            win_valid_d = 1'b1;
          end else begin
            ld_cnt_d = ld_cnt_q + ONE_C;
          end
        end
      end

      S_WAIT: begin
        if (win_valid_q && mac_ready) begin
          win_valid_d = 1'b0;
          rd_cnt_d    = '0;
          if (out_col_q != ow_q - ONE_D) begin
            // Slide right: the new columns continue straight on from the last read.
            state_d   = S_STEP;
            out_col_d = out_col_q + ONE_D;
            rd_en_d   = 1'b1;
            rd_addr_d = rd_addr_q + ONE_A;
          end else if (out_row_q != oh_q - ONE_D) begin
            state_d    = S_FILL;
            out_row_d  = out_row_q + ONE_D;
            out_col_d  = '0;
            row_addr_d = row_addr_q + row_step;
            rd_en_d    = 1'b1;
            rd_addr_d  = row_addr_q + row_step;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_FILL) || (state_d == S_WAIT) || (state_d == S_STEP);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset also drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      load_en_q   <= 1'b0;
      win_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      img_w_q     <= '0;
      ow_q        <= '0;
      oh_q        <= '0;
      row_addr_q  <= '0;
      rd_cnt_q    <= '0;
      ld_cnt_q    <= '0;
      stride2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      load_en_q   <= load_en_d;
      win_valid_q <= win_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      img_w_q     <= img_w_d;
      ow_q        <= ow_d;
      oh_q        <= oh_d;
      row_addr_q  <= row_addr_d;
      rd_cnt_q    <= rd_cnt_d;
      ld_cnt_q    <= ld_cnt_d;
      stride2_q   <= stride2_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign load_en   = load_en_q;
  assign win_valid = win_valid_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
